byte_divider: RTL



---
 rtl/byte_div_pkg.sv | 14 +
 rtl/div_step.sv | 25 ++
 rtl/byte_divider.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/byte_div_pkg.sv
// rtl/byte_div_pkg.sv - shared state type, default width and counter sizing for byte_divider
package byte_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} div_state_e;

  localparam int DIV_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift, trial-subtract, select
module div_step
  import byte_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;

  assign shifted = {rem_i, dvd_i[WIDTH-1]};
  assign diff    = shifted - {2'b00, dvs_i};
  // The top bit of the difference is the borrow of the trial subtraction.
  assign fits    = ~diff[WIDTH+1];
  assign rem_o   = fits ? diff[WIDTH:0] : shifted[WIDTH:0];
  assign dvd_o   = {dvd_i[WIDTH-2:0], fits};

endmodule

// File: rtl/byte_divider.sv
// rtl/byte_divider.sv - sequential restoring divider, one quotient bit per clock
// BYTE_DIVIDER_SIGNED_EN selects two's-complement operands with sign fix-up in FINISH.
module byte_divider
  import byte_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dzo_q, dzo_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_dvd;
  logic [WIDTH-1:0] op_dvd, op_dvs, res_quo, res_rem;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );

`ifdef BYTE_DIVIDER_SIGNED_EN
  logic sq_q, sq_d, sr_q, sr_d;

  assign op_dvd  = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
  assign op_dvs  = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
  assign res_quo = sq_q ? -dvd_q : dvd_q;
  assign res_rem = sr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    sq_d = sq_q;
    sr_d = sr_q;
    if (state_q == IDLE && start_i) begin
      sq_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
      sr_d = dividend_i[WIDTH-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sq_q <= 1'b0;
      sr_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
      sr_q <= sr_d;
    end
  end
`else
  assign op_dvd  = dividend_i;
  assign op_dvs  = divisor_i;
  assign res_quo = dvd_q;
  assign res_rem = rem_q[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dzo_d   = dzo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          rem_d = '0;
          cnt_d = '0;
          dvs_d = op_dvs;
          if (divisor_i == '0) begin
            dz_d    = 1'b1;
            dvd_d   = dividend_i;
            state_d = FINISH;
          end else begin
            dz_d    = 1'b0;
            dvd_d   = op_dvd;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        // A zero divisor lingers one cycle here so its report lands two edges after start.
        if (dz_q && cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          quo_d   = dz_q ? '1 : res_quo;
          rmd_d   = dz_q ? dvd_q : res_rem;
          dzo_d   = dz_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dzo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dzo_q   <= dzo_d;
      done_q  <= done_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rmd_q;
  assign div_zero_o  = dzo_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE);

endmodule
